// File: rtl/i3c_dat_mem_arbiter.sv
// rtl/i3c_dat_mem_arbiter.sv - single-port DAT RAM arbiter between SW (CSR) and HW (command engine)
`ifndef DAT_DEPTH
`define DAT_DEPTH 128
`endif

module i3c_dat_mem_arbiter #(
    parameter int Depth           = `DAT_DEPTH,
    parameter int Width           = 64,
    parameter int DataBitsPerMask = 32,
    parameter int AddrW           = $clog2(Depth),
    parameter int MaxWait         = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sw_req_i,
    input  logic             sw_write_i,
    input  logic [AddrW-1:0] sw_addr_i,
    input  logic [Width-1:0] sw_wdata_i,
    input  logic [Width-1:0] sw_wmask_i,
    output logic             sw_gnt_o,
    output logic             sw_rvalid_o,
    output logic [Width-1:0] sw_rdata_o,
    input  logic             hw_req_i,
    input  logic             hw_write_i,
    input  logic [AddrW-1:0] hw_addr_i,
    input  logic [Width-1:0] hw_wdata_i,
    input  logic [Width-1:0] hw_wmask_i,
    output logic             hw_gnt_o,
    output logic             hw_rvalid_o,
    output logic [Width-1:0] hw_rdata_o,
    input  logic             hw_lock_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [Width-1:0] mem_wmask_o,
    input  logic [Width-1:0] mem_rdata_i,
    input  logic             mem_rvalid_i,
    output logic             stray_rsp_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SW   = 2'd1,
        OWN_HW   = 2'd2
    } owner_e;

    localparam logic [3:0] WaitMax = 4'(MaxWait);

    // Mask granularity is a property of the RAM below; the arbiter passes the full bit mask through.
    logic unused_params;
    assign unused_params = ^DataBitsPerMask;

    owner_e     owner_q, owner_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       lock_owner_q, lock_owner_d;
    logic       stray_q, stray_d;
    logic       lock_active, force_sw;

    // Grant decision, RAM request mux and next-state for counter, lock, owner tag and stray flag.
    always_comb begin
        lock_active  = lock_owner_q & hw_lock_i;
        force_sw     = sw_req_i & ~lock_active & (wait_cnt_q == WaitMax);
        // Grants are held low while in reset so nothing reaches the RAM.
        hw_gnt_o     = rst_ni & hw_req_i & ~force_sw;
        sw_gnt_o     = rst_ni & sw_req_i & ~lock_active & ~hw_gnt_o;
        mem_req_o    = sw_gnt_o | hw_gnt_o;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_wmask_o  = '0;
        if (hw_gnt_o) begin
            mem_write_o = hw_write_i;
            mem_addr_o  = hw_addr_i;
            mem_wdata_o = hw_wdata_i;
            mem_wmask_o = hw_wmask_i;
        end else if (sw_gnt_o) begin
            mem_write_o = sw_write_i;
            mem_addr_o  = sw_addr_i;
            mem_wdata_o = sw_wdata_i;
            mem_wmask_o = sw_wmask_i;
        end

        wait_cnt_d = wait_cnt_q;
        if (!sw_req_i || sw_gnt_o) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        lock_owner_d = lock_owner_q;
        if (!hw_lock_i) begin
            lock_owner_d = 1'b0;
        end else if (hw_gnt_o) begin
            lock_owner_d = 1'b1;
        end

        owner_d = OWN_NONE;
        if (hw_gnt_o && !hw_write_i) begin
            owner_d = OWN_HW;
        end else if (sw_gnt_o && !sw_write_i) begin
            owner_d = OWN_SW;
        end

        stray_d = stray_q | (mem_rvalid_i & (owner_q == OWN_NONE));
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q      <= OWN_NONE;
            wait_cnt_q   <= 4'd0;
            lock_owner_q <= 1'b0;
            stray_q      <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            lock_owner_q <= lock_owner_d;
            stray_q      <= stray_d;
        end
    end

    // Route the one-cycle-late RAM response to whichever port issued the read.
    always_comb begin
        sw_rvalid_o = mem_rvalid_i & (owner_q == OWN_SW);
        hw_rvalid_o = mem_rvalid_i & (owner_q == OWN_HW);
        sw_rdata_o  = rst_ni ? mem_rdata_i : '0;
        hw_rdata_o  = rst_ni ? mem_rdata_i : '0;
        stray_rsp_o = stray_q;
    end

endmodule

// File: tb/tb_i3c_dat_mem_arbiter.sv
// tb/tb_i3c_dat_mem_arbiter.sv - scoreboard bench for i3c_dat_mem_arbiter
module tb_i3c_dat_mem_arbiter;
    localparam int W  = 64;
    localparam int AW = 7;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          sw_req, sw_write, hw_req, hw_write, hw_lock;
    logic [AW-1:0] sw_addr, hw_addr, mem_addr;
    logic [W-1:0]  sw_wdata, sw_wmask, hw_wdata, hw_wmask;
    logic          sw_gnt, hw_gnt, sw_rvalid, hw_rvalid;
    logic [W-1:0]  sw_rdata, hw_rdata;
    logic          mem_req, mem_write, mem_rvalid, ram_rvalid, inject, stray;
    logic [W-1:0]  mem_wdata, mem_wmask, mem_rdata;

    i3c_dat_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .sw_req_i(sw_req), .sw_write_i(sw_write), .sw_addr_i(sw_addr),
        .sw_wdata_i(sw_wdata), .sw_wmask_i(sw_wmask),
        .sw_gnt_o(sw_gnt), .sw_rvalid_o(sw_rvalid), .sw_rdata_o(sw_rdata),
        .hw_req_i(hw_req), .hw_write_i(hw_write), .hw_addr_i(hw_addr),
        .hw_wdata_i(hw_wdata), .hw_wmask_i(hw_wmask),
        .hw_gnt_o(hw_gnt), .hw_rvalid_o(hw_rvalid), .hw_rdata_o(hw_rdata),
        .hw_lock_i(hw_lock),
        .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
        .stray_rsp_o(stray)
    );

    // RAM environment: 1-cycle read latency, bit-masked writes
    logic [W-1:0] ram [DEPTH];
    logic [W-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        ram_rvalid <= mem_req & ~mem_write;
        if (mem_req) begin
            if (mem_write) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else           mem_rdata <= ram[mem_addr];
        end
    end
    assign mem_rvalid = ram_rvalid | inject;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct packed {
        logic         is_sw;
        logic [W-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    logic          g_sw, g_write;
    logic [AW-1:0] g_addr;
    logic [W-1:0]  g_wdata, g_wmask;

    // Scoreboard: pop responses due this cycle, then record what was granted this cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check_eq("one_gnt", {63'd0, sw_gnt & hw_gnt}, 64'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("rsp_sw_rvalid", {63'd0, sw_rvalid}, {63'd0, e.is_sw});
                check_eq("rsp_hw_rvalid", {63'd0, hw_rvalid}, {63'd0, ~e.is_sw});
                check_eq("rsp_data", e.is_sw ? sw_rdata : hw_rdata, e.data);
            end else begin
                check_eq("no_rsp", {62'd0, sw_rvalid, hw_rvalid}, 64'd0);
            end
            if (sw_gnt || hw_gnt) begin
                g_sw    = sw_gnt;
                g_write = g_sw ? sw_write : hw_write;
                g_addr  = g_sw ? sw_addr  : hw_addr;
                g_wdata = g_sw ? sw_wdata : hw_wdata;
                g_wmask = g_sw ? sw_wmask : hw_wmask;
                check_eq("mem_addr", {57'd0, mem_addr}, {57'd0, g_addr});
                check_eq("mem_write", {63'd0, mem_write}, {63'd0, g_write});
                if (g_write)
                    ref_mem[g_addr] = (ref_mem[g_addr] & ~g_wmask) | (g_wdata & g_wmask);
                else
                    exp_q.push_back('{is_sw: g_sw, data: ref_mem[g_addr]});
            end else begin
                check_eq("idle_mem_req", {63'd0, mem_req}, 64'd0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnts(input string tag, input logic exp_sw, input logic exp_hw);
        @(negedge clk);
        check_eq({tag, "_sw_gnt"}, {63'd0, sw_gnt}, {63'd0, exp_sw});
        check_eq({tag, "_hw_gnt"}, {63'd0, hw_gnt}, {63'd0, exp_hw});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = {16'hA5A5, 16'(i), 16'h5A5A, 16'(i * 3)};
            ref_mem[i] = {16'hA5A5, 16'(i), 16'h5A5A, 16'(i * 3)};
        end
        rst_n = 1'b0; inject = 1'b0; hw_lock = 1'b0;
        sw_req = 1'b0; sw_write = 1'b0; sw_addr = '0; sw_wdata = '0; sw_wmask = '1;
        hw_req = 1'b0; hw_write = 1'b0; hw_addr = '0; hw_wdata = '0; hw_wmask = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outputs", {58'd0, sw_gnt, hw_gnt, mem_req, sw_rvalid, hw_rvalid, stray}, 64'd0);
        next_cycle();
        rst_n = 1'b1;

        // 1: SW write then read back
        next_cycle();
        sw_req = 1'b1; sw_write = 1'b1; sw_addr = 7'd3; sw_wdata = 64'hDEAD_BEEF_0000_0001; sw_wmask = '1;
        check_gnts("t1_wr", 1'b1, 1'b0);
        next_cycle();
        sw_write = 1'b0;
        check_gnts("t1_rd", 1'b1, 1'b0);
        next_cycle();
        sw_req = 1'b0;
        @(negedge clk);
        check_eq("t1_rdata", sw_rdata, 64'hDEAD_BEEF_0000_0001);
        check_eq("t1_sw_rvalid", {63'd0, sw_rvalid}, 64'd1);

        // 2: both requesting every cycle, SW forced through every fifth cycle
        next_cycle();
        sw_req = 1'b1; sw_addr = 7'd10; hw_req = 1'b1; hw_write = 1'b0; hw_addr = 7'd11;
        for (int i = 0; i < 10; i++) begin
            check_gnts("t2", (i % 5) == 4, (i % 5) != 4);
        end
        next_cycle();
        sw_req = 1'b0; hw_req = 1'b0;

        // 3: HW lock across read-modify-write of entry 7
        next_cycle();
        hw_req = 1'b1; hw_lock = 1'b1; hw_write = 1'b0; hw_addr = 7'd7;
        sw_req = 1'b1; sw_write = 1'b0; sw_addr = 7'd2;
        check_gnts("t3_rd", 1'b0, 1'b1);
        next_cycle();
        hw_write = 1'b1; hw_wdata = 64'h1111_2222_3333_4444; hw_wmask = 64'hFFFF_FFFF_0000_0000;
        check_gnts("t3_wr", 1'b0, 1'b1);
        next_cycle();
        hw_req = 1'b0; hw_write = 1'b0;
        for (int i = 0; i < 3; i++) check_gnts("t3_held", 1'b0, 1'b0);
        next_cycle();
        hw_lock = 1'b0; hw_req = 1'b1;
        check_gnts("t3_release", 1'b1, 1'b0);
        next_cycle();
        sw_req = 1'b0;
        check_gnts("t3_hw_after", 1'b0, 1'b1);
        next_cycle();
        hw_req = 1'b0; hw_wmask = '1;
        @(negedge clk);
        check_eq("t3_masked", hw_rdata, {32'h1111_2222, 16'h5A5A, 16'd21});

        // 4: alternating reads HW/SW/HW with no bubbles
        next_cycle();
        hw_req = 1'b1; hw_addr = 7'd1;
        check_gnts("t4_a", 1'b0, 1'b1);
        next_cycle();
        hw_req = 1'b0; sw_req = 1'b1; sw_write = 1'b0; sw_addr = 7'd2;
        check_gnts("t4_b", 1'b1, 1'b0);
        next_cycle();
        sw_req = 1'b0; hw_req = 1'b1; hw_addr = 7'd1;
        check_gnts("t4_c", 1'b0, 1'b1);
        next_cycle();
        hw_req = 1'b0;
        @(negedge clk);
        check_eq("t4_last_hw", {62'd0, sw_rvalid, hw_rvalid}, 64'd1);

        // 5: stray response with nothing outstanding
        next_cycle();
        next_cycle();
        inject = 1'b1;
        @(negedge clk);
        check_eq("t5_no_rvalid", {62'd0, sw_rvalid, hw_rvalid}, 64'd0);
        next_cycle();
        inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_stray", {63'd0, stray}, 64'd1);
        end

        // 6: reset the cycle after a SW read grant
        next_cycle();
        sw_req = 1'b1; sw_write = 1'b0; sw_addr = 7'd5;
        check_gnts("t6_rd", 1'b1, 1'b0);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_ctl", {58'd0, sw_gnt, hw_gnt, mem_req, sw_rvalid, hw_rvalid, stray}, 64'd0);
        check_eq("t6_rst_rdata", sw_rdata, 64'd0);
        check_eq("t6_rst_addr", {57'd0, mem_addr}, 64'd0);
        next_cycle();
        rst_n = 1'b1; sw_req = 1'b0;
        @(negedge clk);
        check_eq("t6_post", {62'd0, sw_rvalid, stray}, 64'd0);
        next_cycle();
        sw_req = 1'b1;
        check_gnts("t6_reissue", 1'b1, 1'b0);
        next_cycle();
        sw_req = 1'b0;
        @(negedge clk);
        check_eq("t6_reissue_data", sw_rdata, {16'hA5A5, 16'd5, 16'h5A5A, 16'd15});
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
